// File: rtl/sa_cache_pkg.sv
// sa_cache_pkg: shared state type, line geometry and word-select helper
// for the set-associative instruction cache.
package sa_cache_pkg;
    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, DRAIN} icache_state_e;
    localparam int LINE_W     = 128;
    localparam int MEM_ADDR_W = 8;
    localparam int WORD_SEL_W = 2;
    localparam int LINE_OFS   = 4;
    function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line, input logic [WORD_SEL_W-1:0] sel);
        return line[32*sel +: 32];
    endfunction
endpackage

// File: rtl/sa_cache_way.sv
// sa_cache_way: one way of the icache; tag/valid/data arrays with
// asynchronous read and a single write port.
module sa_cache_way
    import sa_cache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int TAG_W    = MEM_ADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line
);
    logic [NUM_SETS-1:0] valid;
    logic [TAG_W-1:0]    tags  [NUM_SETS];
    logic [LINE_W-1:0]   lines [NUM_SETS];
    always_ff @(posedge clk) begin
        if (!reset_n) valid <= '0;
        else if (wr_en) valid[wr_idx] <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            lines[wr_idx] <= wr_line;
        end
    end
    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_line  = lines[rd_idx];
endmodule

// File: rtl/sa_icache_ctrl.sv
// sa_icache_ctrl: 2-way set-associative icache controller; serves 32-bit
// words from 128-bit lines and refills the victim way from sa_mem on a miss.
module sa_icache_ctrl
    import sa_cache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    localparam int IDX_W   = $clog2(NUM_SETS),
    localparam int TAG_W   = MEM_ADDR_W - IDX_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_req_in,
    input  logic [31:0]           cpu_addr_in,
    output logic [31:0]           cpu_data_out,
    output logic                  cpu_valid_out,
    output logic                  cpu_stall_out,
    output logic                  mem_req_out,
    output logic [MEM_ADDR_W-1:0] mem_addr_out,
    input  logic [LINE_W-1:0]     mem_data_in,
    input  logic                  mem_comp_in
);
    icache_state_e       state, state_d;
    logic [11:2]         addr, addr_d;
    logic [NUM_SETS-1:0] lru, lru_d;
    logic [31:0]         data_d;
    logic                valid_d, req_d, fill, victim, hit0, hit1;
    logic [MEM_ADDR_W-1:0] maddr_d;
    logic                v0, v1;
    logic [TAG_W-1:0]    t0, t1;
    logic [LINE_W-1:0]   l0, l1;
    logic                unused_addr;
    wire [IDX_W-1:0]      idx  = addr[LINE_OFS +: IDX_W];
    wire [TAG_W-1:0]      tag  = addr[11 -: TAG_W];
    wire [WORD_SEL_W-1:0] word = addr[3:2];
    assign unused_addr = ^{cpu_addr_in[31:12], cpu_addr_in[1:0]};
    sa_cache_way #(.NUM_SETS(NUM_SETS)) way0 (
        .clk, .reset_n, .rd_idx(idx), .rd_valid(v0), .rd_tag(t0), .rd_line(l0),
        .wr_en(fill & ~victim), .wr_idx(idx), .wr_tag(tag), .wr_line(mem_data_in)
    );
    sa_cache_way #(.NUM_SETS(NUM_SETS)) way1 (
        .clk, .reset_n, .rd_idx(idx), .rd_valid(v1), .rd_tag(t1), .rd_line(l1),
        .wr_en(fill & victim), .wr_idx(idx), .wr_tag(tag), .wr_line(mem_data_in)
    );
    assign hit0 = v0 && t0 == tag;
    assign hit1 = v1 && t1 == tag;
    // Filling invalid ways first keeps a tag in at most one way of a set.
    assign victim = !v0 ? 1'b0 : !v1 ? 1'b1 : lru[idx];
    assign cpu_stall_out = state != IDLE;
    always_comb begin
        state_d = state;
        addr_d  = addr;
        lru_d   = lru;
        data_d  = cpu_data_out;
        valid_d = 1'b0;
        req_d   = mem_req_out;
        maddr_d = mem_addr_out;
        fill    = 1'b0;
        case (state)
            IDLE: if (cpu_req_in) begin
                addr_d  = cpu_addr_in[11:2];
                state_d = LOOKUP;
            end
            LOOKUP: if (hit0 || hit1) begin
                data_d     = line_word(hit0 ? l0 : l1, word);
                valid_d    = 1'b1;
                lru_d[idx] = hit0;
                state_d    = IDLE;
            end else begin
                req_d   = 1'b1;
                maddr_d = addr[11:4];
                state_d = REFILL;
            end
            REFILL: if (mem_comp_in) begin
                fill       = 1'b1;
                lru_d[idx] = ~victim;
                data_d     = line_word(mem_data_in, word);
                valid_d    = 1'b1;
                req_d      = 1'b0;
                state_d    = DRAIN;
            end
            DRAIN: if (!mem_comp_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        addr <= addr_d;
        if (!reset_n) begin
            state         <= IDLE;
            lru           <= '0;
            cpu_data_out  <= '0;
            cpu_valid_out <= 1'b0;
            mem_req_out   <= 1'b0;
            mem_addr_out  <= '0;
        end else begin
            state         <= state_d;
            lru           <= lru_d;
            cpu_data_out  <= data_d;
            cpu_valid_out <= valid_d;
            mem_req_out   <= req_d;
            mem_addr_out  <= maddr_d;
        end
    end
endmodule

// File: tb/tb_sa_icache_ctrl.sv
// tb_sa_icache_ctrl: directed fetches with queued expected words, checked by
// a monitor against every cpu_valid_out pulse; includes a small sa_mem model.
module tb_sa_icache_ctrl;
    logic         clk = 1'b0, reset_n = 1'b0, cpu_req_in = 1'b0, mem_comp_in = 1'b0;
    logic [31:0]  cpu_addr_in = '0;
    logic [31:0]  cpu_data_out;
    logic         cpu_valid_out, cpu_stall_out, mem_req_out;
    logic [7:0]   mem_addr_out;
    logic [127:0] mem_data_in;
    typedef struct {logic [31:0] data; logic miss;} exp_t;
    exp_t sb[$];
    exp_t e;
    int   total = 0, bad = 0, req_cycles = 0;
    logic [7:0] exp_line = '0;
    logic pend = 1'b0, req_prev = 1'b0;
    always #5 clk = ~clk;
    sa_icache_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cpu_req_in(cpu_req_in), .cpu_addr_in(cpu_addr_in),
        .cpu_data_out(cpu_data_out), .cpu_valid_out(cpu_valid_out), .cpu_stall_out(cpu_stall_out),
        .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
        .mem_data_in(mem_data_in), .mem_comp_in(mem_comp_in)
    );
    // sa_mem line content: word k of line L reads as C5_kk_3A_LL
    assign mem_data_in = {8'hC5, 8'd3, 8'h3A, mem_addr_out, 8'hC5, 8'd2, 8'h3A, mem_addr_out,
                          8'hC5, 8'd1, 8'h3A, mem_addr_out, 8'hC5, 8'd0, 8'h3A, mem_addr_out};
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!reset_n) req_cycles = 0;
        else begin
            if (mem_req_out) begin
                req_cycles++;
                if (!req_prev) begin
                    chk("drain_before_req", {31'd0, mem_comp_in}, 32'd0);
                    chk("mem_addr", {24'd0, mem_addr_out}, {24'd0, exp_line});
                end
            end
            if (cpu_valid_out) begin
                if (sb.size() == 0) chk("extra_valid", {31'd0, cpu_valid_out}, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("data", cpu_data_out, e.data);
                    chk("req_cycles", 32'(req_cycles), e.miss ? 32'd2 : 32'd0);
                end
                req_cycles = 0;
            end
        end
        req_prev = mem_req_out;
        // completion rises two cycles after the request and lingers a cycle after it drops
        mem_comp_in = pend;
        pend = mem_req_out;
    end
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic miss, input logic tog);
        int n;
        n = 0;
        while (cpu_stall_out && n < 20) begin @(negedge clk); n++; end
        sb.push_back('{d, miss});
        exp_line = a[11:4];
        cpu_addr_in = a;
        cpu_req_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (tog && !cpu_valid_out) cpu_req_in = ~cpu_req_in;
        end while (!cpu_valid_out && n < 20);
        cpu_req_in = 1'b0;
        chk("fetch_lat", 32'(n), miss ? 32'd4 : 32'd2);
        n = 0;
        while (cpu_stall_out && n < 10) begin @(negedge clk); n++; end
        chk("idle_lat", 32'(n), miss ? 32'd2 : 32'd0);
    endtask
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, cpu_data_out, 32'd0);
        chk({tag, "_valid"}, {31'd0, cpu_valid_out}, 32'd0);
        chk({tag, "_req"}, {31'd0, mem_req_out}, 32'd0);
        chk({tag, "_maddr"}, {24'd0, mem_addr_out}, 32'd0);
        chk({tag, "_stall"}, {31'd0, cpu_stall_out}, 32'd0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        fetch(32'h010, 32'hC5003A01, 1'b1, 1'b0);
        fetch(32'h010, 32'hC5003A01, 1'b0, 1'b0);
        fetch(32'h01C, 32'hC5033A01, 1'b0, 1'b0);
        fetch(32'hABCDE01F, 32'hC5033A01, 1'b0, 1'b0);
        fetch(32'h000, 32'hC5003A00, 1'b1, 1'b0);
        fetch(32'h080, 32'hC5003A08, 1'b1, 1'b0);
        fetch(32'h000, 32'hC5003A00, 1'b0, 1'b0);
        fetch(32'h100, 32'hC5003A10, 1'b1, 1'b0);
        fetch(32'h000, 32'hC5003A00, 1'b0, 1'b0);
        fetch(32'h080, 32'hC5003A08, 1'b1, 1'b0);
        fetch(32'h000, 32'hC5003A00, 1'b0, 1'b0);
        fetch(32'h100, 32'hC5003A10, 1'b1, 1'b0);
        fetch(32'h020, 32'hC5003A02, 1'b1, 1'b0);
        fetch(32'h040, 32'hC5003A04, 1'b1, 1'b0);
        fetch(32'h024, 32'hC5013A02, 1'b0, 1'b0);
        fetch(32'h048, 32'hC5023A04, 1'b0, 1'b0);
        exp_line = 8'h30;
        cpu_addr_in = 32'h300;
        cpu_req_in = 1'b1;
        @(negedge clk);
        cpu_req_in = 1'b0;
        @(negedge clk);
        chk("refill_req", {31'd0, mem_req_out}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midfill_rst_req", {31'd0, mem_req_out}, 32'd0);
        chk("midfill_rst_valid", {31'd0, cpu_valid_out}, 32'd0);
        repeat (2) @(negedge clk);
        check_reset_outputs("midfill_rst");
        reset_n = 1'b1;
        fetch(32'h300, 32'hC5003A30, 1'b1, 1'b0);
        fetch(32'h010, 32'hC5003A01, 1'b1, 1'b0);
        fetch(32'h010, 32'hC5003A01, 1'b0, 1'b1);
        fetch(32'h500, 32'hC5003A50, 1'b1, 1'b1);
        fetch(32'h504, 32'hC5013A50, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
